// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed at issue into pending registers and committed after a fixed busy period.
module md_unit #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] NumberA,
    input  logic [31:0] NumberB,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT);
    localparam logic [CW-1:0] ONE_CNT = CW'(1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   phi_q, phi_d, plo_q, plo_d;
    logic          commit_q, commit_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        is_signed, a_neg, b_neg;
    logic [63:0] mul_a, mul_b, prod;
    logic [31:0] a_mag, b_mag, div_b, uq, ur, quot, rem;

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000
    // instead of overflowing; a zero divisor is replaced by 1 to keep values defined.
    always_comb begin
        is_signed = (MDOp == OP_MULT) || (MDOp == OP_DIV);
        a_neg     = is_signed & NumberA[31];
        b_neg     = is_signed & NumberB[31];
        mul_a     = {{32{a_neg}}, NumberA};
        mul_b     = {{32{b_neg}}, NumberB};
        prod      = mul_a * mul_b;
        a_mag     = a_neg ? (~NumberA + 32'd1) : NumberA;
        b_mag     = b_neg ? (~NumberB + 32'd1) : NumberB;
        div_b     = (NumberB == 32'd0) ? 32'd1 : b_mag;
        uq        = a_mag / div_b;
        ur        = a_mag % div_b;
        quot      = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
        rem       = a_neg ? (~ur + 32'd1) : ur;
    end

    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        phi_d    = phi_q;
        plo_d    = plo_q;
        commit_d = commit_q;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        if (busy_q) begin
            // Any Start while busy, including on the commit edge, is dropped.
            if (cnt_q == ONE_CNT) begin
                busy_d = 1'b0;
                cnt_d  = '0;
                if (commit_q) begin
                    hi_d = phi_q;
                    lo_d = plo_q;
                end
            end else begin
                cnt_d = cnt_q - ONE_CNT;
            end
        end else if (Start) begin
            case (MDOp)
                OP_MULT, OP_MULTU: begin
                    phi_d    = prod[63:32];
                    plo_d    = prod[31:0];
                    commit_d = 1'b1;
                    cnt_d    = MUL_CNT;
                    busy_d   = 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                    phi_d    = rem;
                    plo_d    = quot;
                    commit_d = (NumberB != 32'd0);
                    cnt_d    = DIV_CNT;
                    busy_d   = 1'b1;
                end
                OP_MTHI: hi_d = NumberA;
                OP_MTLO: lo_d = NumberA;
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hi_q     <= '0;
            lo_q     <= '0;
            phi_q    <= '0;
            plo_q    <= '0;
            commit_q <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            phi_q    <= phi_d;
            plo_q    <= plo_d;
            commit_q <= commit_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: issued ops push {busy length, HI, LO} into a queue;
// a monitor pops on each falling Busy and compares.
module tb_md_unit;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] NumberA;
    logic [31:0] NumberB;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_vec = 0;
    int n_err = 0;

    logic [71:0] exp_q[$];

    md_unit #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .MDOp(MDOp),
        .NumberA(NumberA), .NumberB(NumberB),
        .Busy(Busy), .HI(HI), .LO(LO)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start   = 1'b1;
        MDOp    = op;
        NumberA = a;
        NumberB = b;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        MDOp  = 3'd0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] lat, input logic [31:0] ehi, input logic [31:0] elo);
        exp_q.push_back({lat, ehi, elo});
        do_op(op, a, b);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (!Busy) return;
        end
        check({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    // scoreboard monitor
    logic busy_prev = 1'b0;
    int   busy_cnt  = 0;
    always @(negedge Clk) begin
        logic [71:0] e;
        if (!Reset) begin
            busy_prev = 1'b0;
            busy_cnt  = 0;
        end else begin
            if (Busy) busy_cnt++;
            if (busy_prev && !Busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_commit", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("busy_len", busy_cnt, {24'd0, e[71:64]});
                    check("commit_hi", HI, e[63:32]);
                    check("commit_lo", LO, e[31:0]);
                end
                busy_cnt = 0;
            end
            busy_prev = Busy;
        end
    end

    initial begin
        Reset = 1'b0; Start = 1'b0; MDOp = 3'd0; NumberA = '0; NumberB = '0;
        repeat (2) @(negedge Clk);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        @(posedge Clk); #3 Reset = 1'b1;
        @(negedge Clk);

        // signed mult, HI/LO hold during busy
        issue(3'd1, 32'hFFFFFFFF, 32'h00000002, 8'd5, 32'hFFFFFFFF, 32'hFFFFFFFE);
        @(negedge Clk);
        check("mult_busy", {31'd0, Busy}, 32'd1);
        check("mult_hold_hi", HI, 32'd0);
        check("mult_hold_lo", LO, 32'd0);
        wait_idle("mult");

        issue(3'd2, 32'hFFFFFFFF, 32'h00000002, 8'd5, 32'h00000001, 32'hFFFFFFFE);
        wait_idle("multu");
        issue(3'd1, 32'hFFFFFFFD, 32'hFFFFFFFC, 8'd5, 32'h00000000, 32'h0000000C);
        wait_idle("mult_negneg");
        issue(3'd3, 32'hFFFFFFF9, 32'h00000002, 8'd10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        wait_idle("div_neg");
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 8'd10, 32'h00000000, 32'h80000000);
        wait_idle("div_ovf");
        issue(3'd4, 32'd100, 32'd7, 8'd10, 32'd2, 32'd14);
        wait_idle("divu");

        // mthi/mtlo then divide by zero leaves HI/LO alone
        do_op(3'd5, 32'h00000011, 32'd0);
        @(negedge Clk);
        check("mthi_hi", HI, 32'h11);
        check("mthi_busy", {31'd0, Busy}, 32'd0);
        do_op(3'd6, 32'h00000022, 32'd0);
        @(negedge Clk);
        check("mtlo_lo", LO, 32'h22);
        check("mtlo_hi_kept", HI, 32'h11);
        issue(3'd4, 32'h00000055, 32'd0, 8'd10, 32'h11, 32'h22);
        wait_idle("divu_zero");

        // mthi while idle, then mtlo dropped while busy
        do_op(3'd5, 32'hAAAA5555, 32'd0);
        @(negedge Clk);
        check("mthi2_hi", HI, 32'hAAAA5555);
        check("mthi2_lo_kept", LO, 32'h22);
        check("mthi2_busy", {31'd0, Busy}, 32'd0);
        issue(3'd2, 32'd3, 32'd4, 8'd5, 32'd0, 32'd12);
        @(negedge Clk);
        do_op(3'd6, 32'h00001234, 32'd0);
        wait_idle("multu_mtlo");

        // Start held through the commit edge is ignored
        exp_q.push_back({8'd5, 32'hFFFFFFFE, 32'h00000001});
        Start = 1'b1; MDOp = 3'd2; NumberA = 32'hFFFFFFFF; NumberB = 32'hFFFFFFFF;
        @(posedge Clk); #1;
        MDOp = 3'd5; NumberA = 32'h0000DEAD;
        repeat (5) begin @(posedge Clk); #1; end
        Start = 1'b0; MDOp = 3'd0;
        @(negedge Clk);
        check("commit_edge_hi", HI, 32'hFFFFFFFE);
        check("commit_edge_busy", {31'd0, Busy}, 32'd0);

        // reset in the middle of a divide
        do_op(3'd3, 32'd100, 32'd7);
        repeat (3) @(negedge Clk);
        @(posedge Clk); #2 Reset = 1'b0;
        #1;
        check("midrst_busy", {31'd0, Busy}, 32'd0);
        check("midrst_hi", HI, 32'd0);
        check("midrst_lo", LO, 32'd0);
        @(negedge Clk);
        @(posedge Clk); #3 Reset = 1'b1;
        repeat (12) @(negedge Clk);
        check("postrst_busy", {31'd0, Busy}, 32'd0);
        check("postrst_hi", HI, 32'd0);
        check("postrst_lo", LO, 32'd0);
        issue(3'd1, 32'd7, 32'hFFFFFFFE, 8'd5, 32'hFFFFFFFF, 32'hFFFFFFF2);
        wait_idle("mult_after_rst");

        // final report
        @(negedge Clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
